issue_scheduler: RTL and testbench
==================================

# issue_scheduler

- Out-of-order issue queue between rename/dispatch and `register_read`.
- Buffers dispatched instructions in an age-ordered collapsing queue and tracks per-source readiness through writeback wakeup broadcasts.
- Each cycle it fires the oldest fully-ready instruction.
- It drives the `fire_valid` / `sched_pkt` fields of `scheduler_reg_read_if`.

## Interface
Parameters:
- `NUM_ENTRIES`, default 8: queue depth, power of two, 2..32.
- `PREG_W`, default `$clog2(NUM_PREGS)` from `CORE_PKG`: physical register tag width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all entries and of the fire register.
- `disp_valid`  in  1  dispatch request.
- `disp_ready`  out  1  queue can accept this cycle.
- `disp_pc`  in  32  instruction PC.
- `disp_src1_preg`, `disp_src2_preg`, `disp_dst_preg`  in  PREG_W each  physical tags.
- `disp_src1_rdy`, `disp_src2_rdy`  in  1 each  source already available per rename busy table.
- `disp_imm_val`  in  32  immediate.
- `wb_valid`  in  1  writeback wakeup broadcast valid.
- `wb_preg`  in  PREG_W  tag being written back.
- `fire_valid`  out  1  registered: `sched_pkt` holds an issued instruction.
- `sched_pkt`  out  struct  registered `{pc, src1_preg, src2_preg, dst_preg, imm_val, instr_valid}`.
- `count`  out  $clog2(NUM_ENTRIES)+1  occupied entries.

## Operation
- Each entry holds: valid, pc, the three tags, imm, r1, r2.
- Entry 0 is always the oldest entry. Valid entries occupy indices 0..count-1 contiguously.
- Wakeup: when `wb_valid` is high, every valid entry whose src tag equals `wb_preg` sets that source's r bit at the next edge.
- Tag 0 is always ready: sources with preg 0 are forced ready at dispatch.
- Dispatch wakeup: a dispatching source whose tag equals `wb_preg` while `wb_valid` is high is stored ready (same-cycle capture).
- Select:
  - Compute `rdy_vec[i] = valid & r1 & r2` from registered state only.
  - Pick the lowest index set.
  - A wakeup in cycle N makes an entry selectable no earlier than cycle N+1.
- Fire:
  - The selected entry loads into the fire register with `instr_valid = 1`, and `fire_valid` goes high for one cycle.
  - When no entry is ready, `fire_valid` = 0 and `sched_pkt` keeps its previous contents.
  - There is no backpressure: at most one fire per cycle.
- Collapse: when index k fires, entries k+1..count-1 shift down by one. Their wakeups that cycle are applied at their shifted position.
- Dispatch write: the new entry goes to index `count`, or to index `count-1` if a fire also happens this cycle.
- `disp_ready` = (count < NUM_ENTRIES). It is combinational from registered count and does not credit the same-cycle fire.
- Flush: at the next edge all valid bits clear, count = 0, fire_valid = 0. A dispatch in the flush cycle is dropped.

## Timing
- Reset values (asynchronous on `rst`=0):
  - all entry valid = 0, count = 0;
  - `fire_valid` = 0, `sched_pkt` = '0;
  - `disp_ready` = 1 after reset.
- Latency: an instruction dispatched ready at edge N is in the queue after N and fires with `fire_valid`=1 after edge N+1.
- Wakeup to fire: `wb` in cycle N, r bit set at edge N, then `fire_valid` after edge N+1.
- Full (count = NUM_ENTRIES): `disp_ready`=0. A simultaneous fire frees one slot visible the following cycle.
- Empty with dispatch: fire is not possible that same cycle (no bypass through the queue).
- Flush has priority over dispatch, fire and wakeup in the same cycle.
- Reset mid-operation: all state clears immediately regardless of `clk`.

## Configuration
- `SCHED_PERF_CNT_EN` defined: adds two 32-bit outputs.
  - `perf_full_cycles` increments each cycle with `disp_valid` & !`disp_ready`.
  - `perf_fires` increments per fire.
  - Both wrap at 2^32, clear on reset, and are unaffected by `flush`.
- Not defined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then dispatch pc=0x1000, src 5/10 both rdy, dst 15, imm 0x42 at edge N.
  - Required: after N+1, fire_valid=1, sched_pkt.pc=0x1000, src1=5, src2=10, dst=15, imm=0x42, instr_valid=1.
  - Required: count back to 0.
- Dispatch A (pc 0x2000, src1=7 not rdy), then B (pc 0x2004, both rdy).
  - Required: B fires first.
  - Then `wb_valid`=1 with wb_preg=7. Required: A fires exactly two edges later with pc 0x2000.
- Dispatch with src1=9 not rdy while wb_valid=1, wb_preg=9 in the same cycle.
  - Required: fires one edge after dispatch, with no further wakeup.
- Fill 8 non-ready entries. Required: count=8, disp_ready=0.
  - Wake all. Required: fires in dispatch order, one per cycle.
  - While firing, dispatch a 9th entry. Required: accepted only after disp_ready rises, and it fires last.
- Three entries with one ready, assert flush in the same cycle as a dispatch.
  - Required: next cycle count=0, fire_valid=0, and nothing fires afterwards.
- Assert rst=0 between clock edges with count=3.
  - Required: count=0, fire_valid=0 and sched_pkt='0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: an age-ordered collapsing buffer with writeback wakeup and oldest-ready select.
// Optional macro SCHED_PERF_CNT_EN adds the perf_full_cycles / perf_fires counters.
`timescale 1ns/1ps

package core_pkg;
   localparam int NUM_PREGS = 64;
   localparam int PREG_W    = $clog2(NUM_PREGS);

   typedef struct packed {
      logic [31:0]       pc;
      logic [PREG_W-1:0] src1_preg;
      logic [PREG_W-1:0] src2_preg;
      logic [PREG_W-1:0] dst_preg;
      logic [31:0]       imm_val;
      logic              instr_valid;
   } sched_pkt_t;
endpackage

// Per-entry readiness: registered ready flag plus the wakeup-updated source bits.
module issue_sched_slot #(
   parameter int PREG_W = 6
) (
   input  logic              valid,
   input  logic [PREG_W-1:0] src1_preg,
   input  logic [PREG_W-1:0] src2_preg,
   input  logic              r1,
   input  logic              r2,
   input  logic              wb_valid,
   input  logic [PREG_W-1:0] wb_preg,
   output logic              r1_w,
   output logic              r2_w,
   output logic              rdy
);
   assign rdy  = valid & r1 & r2;
   assign r1_w = r1 | (wb_valid & (src1_preg == wb_preg));
   assign r2_w = r2 | (wb_valid & (src2_preg == wb_preg));
endmodule

module issue_scheduler #(
   parameter int NUM_ENTRIES = 8,
   parameter int PREG_W      = core_pkg::PREG_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         disp_valid,
   output logic                         disp_ready,
   input  logic [31:0]                  disp_pc,
   input  logic [PREG_W-1:0]            disp_src1_preg,
   input  logic [PREG_W-1:0]            disp_src2_preg,
   input  logic [PREG_W-1:0]            disp_dst_preg,
   input  logic                         disp_src1_rdy,
   input  logic                         disp_src2_rdy,
   input  logic [31:0]                  disp_imm_val,
   input  logic                         wb_valid,
   input  logic [PREG_W-1:0]            wb_preg,
   output logic                         fire_valid,
   output core_pkg::sched_pkt_t         sched_pkt,
   output logic [$clog2(NUM_ENTRIES):0] count
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [31:0]                  perf_full_cycles,
   output logic [31:0]                  perf_fires
`endif
);
   localparam int IW = $clog2(NUM_ENTRIES);
   localparam int CW = IW + 1;

   logic [NUM_ENTRIES-1:0]             valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
   logic [NUM_ENTRIES-1:0][31:0]       pc_q, pc_d, imm_q, imm_d;
   logic [NUM_ENTRIES-1:0][PREG_W-1:0] s1_q, s1_d, s2_q, s2_d, dst_q, dst_d;
   logic [CW-1:0]                      count_q, count_d;
   logic                               fire_valid_q, fire_valid_d;
   core_pkg::sched_pkt_t               pkt_q, pkt_d;

   logic [NUM_ENTRIES-1:0]             rdy_vec, r1_w, r2_w, shift_vec;
   logic [NUM_ENTRIES-1:0]             sh_valid, sh_r1, sh_r2;
   logic [NUM_ENTRIES-1:0][31:0]       sh_pc, sh_imm;
   logic [NUM_ENTRIES-1:0][PREG_W-1:0] sh_s1, sh_s2, sh_dst;

   logic [IW-1:0] sel_idx, wr_idx;
   logic          fire_any, disp_acc, fire_go, disp_r1, disp_r2;

   // Each slot reads its upper neighbour so the queue can close the gap left by a fire.
   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_slot
      localparam int NXT = (g < NUM_ENTRIES-1) ? g + 1 : g;
      logic up_valid;

      issue_sched_slot #(.PREG_W(PREG_W)) u_slot (
         .valid     (valid_q[g]),
         .src1_preg (s1_q[g]),
         .src2_preg (s2_q[g]),
         .r1        (r1_q[g]),
         .r2        (r2_q[g]),
         .wb_valid  (wb_valid),
         .wb_preg   (wb_preg),
         .r1_w      (r1_w[g]),
         .r2_w      (r2_w[g]),
         .rdy       (rdy_vec[g])
      );

      assign shift_vec[g] = fire_any & (IW'(g) >= sel_idx);
      assign up_valid     = (g < NUM_ENTRIES-1) ? valid_q[NXT] : 1'b0;
      assign sh_valid[g]  = shift_vec[g] ? up_valid    : valid_q[g];
      assign sh_pc[g]     = shift_vec[g] ? pc_q[NXT]   : pc_q[g];
      assign sh_imm[g]    = shift_vec[g] ? imm_q[NXT]  : imm_q[g];
      assign sh_s1[g]     = shift_vec[g] ? s1_q[NXT]   : s1_q[g];
      assign sh_s2[g]     = shift_vec[g] ? s2_q[NXT]   : s2_q[g];
      assign sh_dst[g]    = shift_vec[g] ? dst_q[NXT]  : dst_q[g];
      assign sh_r1[g]     = shift_vec[g] ? r1_w[NXT]   : r1_w[g];
      assign sh_r2[g]     = shift_vec[g] ? r2_w[NXT]   : r2_w[g];
   end

   always_comb begin
      sel_idx = '0;
      for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
         if (rdy_vec[i]) sel_idx = IW'(i);
      end
   end

   assign fire_any   = |rdy_vec;
   assign fire_go    = fire_any & ~flush;
   assign disp_ready = (count_q < CW'(NUM_ENTRIES));
   assign disp_acc   = disp_valid & disp_ready & ~flush;
   // The write slot only wraps to count-1 when a fire frees space; count_q < N whenever disp_acc.
   assign wr_idx     = IW'(fire_any ? count_q - 1'b1 : count_q);
   assign disp_r1    = disp_src1_rdy | (disp_src1_preg == '0) |
                       (wb_valid & (disp_src1_preg == wb_preg));
   assign disp_r2    = disp_src2_rdy | (disp_src2_preg == '0) |
                       (wb_valid & (disp_src2_preg == wb_preg));

   always_comb begin
      valid_d = sh_valid;
      pc_d    = sh_pc;
      imm_d   = sh_imm;
      s1_d    = sh_s1;
      s2_d    = sh_s2;
      dst_d   = sh_dst;
      r1_d    = sh_r1;
      r2_d    = sh_r2;
      if (disp_acc) begin
         valid_d[wr_idx] = 1'b1;
         pc_d[wr_idx]    = disp_pc;
         imm_d[wr_idx]   = disp_imm_val;
         s1_d[wr_idx]    = disp_src1_preg;
         s2_d[wr_idx]    = disp_src2_preg;
         dst_d[wr_idx]   = disp_dst_preg;
         r1_d[wr_idx]    = disp_r1;
         r2_d[wr_idx]    = disp_r2;
      end
      if (flush) valid_d = '0;
   end

   always_comb begin
      count_d      = count_q - CW'(fire_any) + CW'(disp_acc);
      fire_valid_d = fire_go;
      pkt_d        = pkt_q;
      if (flush) count_d = '0;
      if (fire_go) begin
         pkt_d.pc          = pc_q[sel_idx];
         pkt_d.src1_preg   = s1_q[sel_idx];
         pkt_d.src2_preg   = s2_q[sel_idx];
         pkt_d.dst_preg    = dst_q[sel_idx];
         pkt_d.imm_val     = imm_q[sel_idx];
         pkt_d.instr_valid = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= '0;
         r1_q         <= '0;
         r2_q         <= '0;
         pc_q         <= '0;
         imm_q        <= '0;
         s1_q         <= '0;
         s2_q         <= '0;
         dst_q        <= '0;
         count_q      <= '0;
         fire_valid_q <= 1'b0;
         pkt_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         r1_q         <= r1_d;
         r2_q         <= r2_d;
         pc_q         <= pc_d;
         imm_q        <= imm_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         dst_q        <= dst_d;
         count_q      <= count_d;
         fire_valid_q <= fire_valid_d;
         pkt_q        <= pkt_d;
      end
   end

   assign fire_valid = fire_valid_q;
   assign sched_pkt  = pkt_q;
   assign count      = count_q;

`ifdef SCHED_PERF_CNT_EN
   logic [31:0] perf_full_q, perf_full_d, perf_fires_q, perf_fires_d;

   // Counters ignore flush; only reset clears them.
   always_comb begin
      perf_full_d  = perf_full_q + {31'd0, disp_valid & ~disp_ready};
      perf_fires_d = perf_fires_q + {31'd0, fire_go};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_full_q  <= '0;
         perf_fires_q <= '0;
      end else begin
         perf_full_q  <= perf_full_d;
         perf_fires_q <= perf_fires_d;
      end
   end

   assign perf_full_cycles = perf_full_q;
   assign perf_fires       = perf_fires_q;
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: latency, wakeup, collapse ordering, full, flush and async reset.
`timescale 1ns/1ps

module tb_issue_scheduler;
   localparam int N  = 8;
   localparam int PW = core_pkg::PREG_W;

   logic                 clk, rst, flush;
   logic                 disp_valid, disp_ready;
   logic [31:0]          disp_pc, disp_imm_val;
   logic [PW-1:0]        disp_src1_preg, disp_src2_preg, disp_dst_preg;
   logic                 disp_src1_rdy, disp_src2_rdy;
   logic                 wb_valid;
   logic [PW-1:0]        wb_preg;
   logic                 fire_valid;
   core_pkg::sched_pkt_t sched_pkt;
   logic [$clog2(N):0]   count;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0]          perf_full_cycles, perf_fires;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   issue_scheduler #(.NUM_ENTRIES(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .disp_valid     (disp_valid),
      .disp_ready     (disp_ready),
      .disp_pc        (disp_pc),
      .disp_src1_preg (disp_src1_preg),
      .disp_src2_preg (disp_src2_preg),
      .disp_dst_preg  (disp_dst_preg),
      .disp_src1_rdy  (disp_src1_rdy),
      .disp_src2_rdy  (disp_src2_rdy),
      .disp_imm_val   (disp_imm_val),
      .wb_valid       (wb_valid),
      .wb_preg        (wb_preg),
      .fire_valid     (fire_valid),
      .sched_pkt      (sched_pkt),
      .count          (count)
`ifdef SCHED_PERF_CNT_EN
      ,
      .perf_full_cycles (perf_full_cycles),
      .perf_fires       (perf_fires)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_disp(input logic [31:0] pc, input logic [PW-1:0] s1, input logic [PW-1:0] s2,
                             input logic [PW-1:0] d, input logic r1, input logic r2,
                             input logic [31:0] imm);
      disp_valid     = 1'b1;
      disp_pc        = pc;
      disp_src1_preg = s1;
      disp_src2_preg = s2;
      disp_dst_preg  = d;
      disp_src1_rdy  = r1;
      disp_src2_rdy  = r2;
      disp_imm_val   = imm;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; wb_valid = 1'b0; wb_preg = '0;
      disp_pc = '0; disp_imm_val = '0; disp_src1_preg = '0; disp_src2_preg = '0;
      disp_dst_preg = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;

      // reset state
      #12;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_fire", 64'(fire_valid), 64'd0);
      chk("rst_pkt_zero", 64'(sched_pkt == '0), 64'd1);
      chk("rst_disp_ready", 64'(disp_ready), 64'd1);
      rst = 1'b1;

      // basic latency: dispatch ready at edge N, fires after N+1
      drive_disp(32'h1000, 6'd5, 6'd10, 6'd15, 1'b1, 1'b1, 32'h42);
      tick();
      disp_valid = 1'b0;
      chk("t1_count_after_disp", 64'(count), 64'd1);
      chk("t1_no_bypass", 64'(fire_valid), 64'd0);
      tick();
      chk("t1_fire", 64'(fire_valid), 64'd1);
      chk("t1_pc", 64'(sched_pkt.pc), 64'h1000);
      chk("t1_src1", 64'(sched_pkt.src1_preg), 64'd5);
      chk("t1_src2", 64'(sched_pkt.src2_preg), 64'd10);
      chk("t1_dst", 64'(sched_pkt.dst_preg), 64'd15);
      chk("t1_imm", 64'(sched_pkt.imm_val), 64'h42);
      chk("t1_ivalid", 64'(sched_pkt.instr_valid), 64'd1);
      chk("t1_count_empty", 64'(count), 64'd0);
      tick();
      chk("t1_fire_one_cycle", 64'(fire_valid), 64'd0);
      chk("t1_pkt_held", 64'(sched_pkt.pc), 64'h1000);

      // younger ready B overtakes waiting A; A fires two edges after its wakeup
      drive_disp(32'h2000, 6'd7, 6'd3, 6'd20, 1'b0, 1'b1, 32'h1);
      tick();
      drive_disp(32'h2004, 6'd4, 6'd6, 6'd21, 1'b1, 1'b1, 32'h2);
      tick();
      disp_valid = 1'b0;
      chk("t2_fire_none_yet", 64'(fire_valid), 64'd0);
      tick();
      chk("t2_b_fires", 64'(fire_valid), 64'd1);
      chk("t2_b_pc", 64'(sched_pkt.pc), 64'h2004);
      chk("t2_count", 64'(count), 64'd1);
      wb_valid = 1'b1; wb_preg = 6'd7;
      tick();
      wb_valid = 1'b0;
      chk("t2_wake_not_same_edge", 64'(fire_valid), 64'd0);
      tick();
      chk("t2_a_fires", 64'(fire_valid), 64'd1);
      chk("t2_a_pc", 64'(sched_pkt.pc), 64'h2000);
      chk("t2_count_empty", 64'(count), 64'd0);

      // same-cycle dispatch wakeup; src2 tag 0 counts as ready
      drive_disp(32'h3000, 6'd9, 6'd0, 6'd22, 1'b0, 1'b0, 32'h33);
      wb_valid = 1'b1; wb_preg = 6'd9;
      tick();
      disp_valid = 1'b0; wb_valid = 1'b0;
      chk("t3_count", 64'(count), 64'd1);
      chk("t3_no_fire_yet", 64'(fire_valid), 64'd0);
      tick();
      chk("t3_fire", 64'(fire_valid), 64'd1);
      chk("t3_pc", 64'(sched_pkt.pc), 64'h3000);
      chk("t3_imm", 64'(sched_pkt.imm_val), 64'h33);

      // fill, wake in order, 9th entry waits for disp_ready and fires last
      for (int i = 0; i < N; i++) begin
         drive_disp(32'h4000 + 32'(4*i), 6'(10+i), 6'd0, 6'(30+i), 1'b0, 1'b0, 32'(i));
         tick();
      end
      chk("t4_full_count", 64'(count), 64'd8);
      chk("t4_full_ready", 64'(disp_ready), 64'd0);
      chk("t4_full_no_fire", 64'(fire_valid), 64'd0);
      drive_disp(32'h4100, 6'd1, 6'd2, 6'd40, 1'b1, 1'b1, 32'h99);
      for (int k = 0; k <= N; k++) begin
         wb_valid = (k < N);
         wb_preg  = 6'(10+k);
         if (k == 3) disp_valid = 1'b0;
         if (k < 3) chk("t4_disp_ready", 64'(disp_ready), 64'(k == 2));
         tick();
         if (k == 0) begin
            chk("t4_fire_k0", 64'(fire_valid), 64'd0);
            chk("t4_count_k0", 64'(count), 64'd8);
         end else begin
            chk("t4_fire_k", 64'(fire_valid), 64'd1);
            chk("t4_pc_k", 64'(sched_pkt.pc), 64'h4000 + 64'(4*(k-1)));
            chk("t4_count_k", 64'(count), (k == 1) ? 64'd7 : 64'(9-k));
         end
      end
      wb_valid = 1'b0;
      tick();
      chk("t4_ninth_fire", 64'(fire_valid), 64'd1);
      chk("t4_ninth_pc", 64'(sched_pkt.pc), 64'h4100);
      chk("t4_count_empty", 64'(count), 64'd0);
      tick();
      chk("t4_idle", 64'(fire_valid), 64'd0);

      // flush with concurrent dispatch and a ready entry
      drive_disp(32'h5000, 6'd40, 6'd0, 6'd1, 1'b0, 1'b1, 32'h0);
      tick();
      drive_disp(32'h5004, 6'd41, 6'd0, 6'd2, 1'b0, 1'b1, 32'h0);
      tick();
      drive_disp(32'h5008, 6'd3, 6'd4, 6'd5, 1'b1, 1'b1, 32'h0);
      tick();
      chk("t5_count3", 64'(count), 64'd3);
      flush = 1'b1;
      drive_disp(32'h5100, 6'd3, 6'd4, 6'd6, 1'b1, 1'b1, 32'h0);
      tick();
      flush = 1'b0; disp_valid = 1'b0;
      chk("t5_flush_count", 64'(count), 64'd0);
      chk("t5_flush_fire", 64'(fire_valid), 64'd0);
      chk("t5_flush_ready", 64'(disp_ready), 64'd1);
      wb_valid = 1'b1; wb_preg = 6'd40;
      tick();
      wb_preg = 6'd41;
      tick();
      chk("t5_post_fire_a", 64'(fire_valid), 64'd0);
      wb_valid = 1'b0;
      tick();
      chk("t5_post_fire_b", 64'(fire_valid), 64'd0);
      chk("t5_post_count", 64'(count), 64'd0);

      // asynchronous reset between edges with count = 3
      drive_disp(32'h6000, 6'd50, 6'd0, 6'd1, 1'b0, 1'b1, 32'h0);
      tick();
      drive_disp(32'h6004, 6'd51, 6'd0, 6'd2, 1'b0, 1'b1, 32'h0);
      tick();
      drive_disp(32'h6008, 6'd52, 6'd0, 6'd3, 1'b0, 1'b1, 32'h0);
      tick();
      drive_disp(32'h600C, 6'd7, 6'd8, 6'd4, 1'b1, 1'b1, 32'h77);
      tick();
      disp_valid = 1'b0;
      tick();
      chk("t6_pre_count", 64'(count), 64'd3);
      chk("t6_pre_fire", 64'(fire_valid), 64'd1);
      chk("t6_pre_pc", 64'(sched_pkt.pc), 64'h600C);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_count", 64'(count), 64'd0);
      chk("t6_async_fire", 64'(fire_valid), 64'd0);
      chk("t6_async_pkt", 64'(sched_pkt == '0), 64'd1);
      chk("t6_async_ready", 64'(disp_ready), 64'd1);
      #2 rst = 1'b1;
      tick();
      chk("t6_after_fire", 64'(fire_valid), 64'd0);
      chk("t6_after_count", 64'(count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
